// File: rtl/tape_controller.sv
// tape_controller: Turing-machine sequencer driving an 8-cell tape from a programmable rule table
module tape_controller #(
  parameter int SIZE      = 2,
  parameter int STATE_W   = 3,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                start_head,
  input  logic                      rule_wr_ena,
  input  logic [STATE_W+SIZE-1:0]   rule_addr,
  input  logic [STATE_W+SIZE+1:0]   rule_data,
  input  logic [SIZE-1:0]           tape_read_data,
  output logic [2:0]                tape_head,
  output logic                      tape_write_ena,
  output logic [SIZE-1:0]           tape_write_data,
  output logic                      busy,
  output logic                      halted,
  output logic                      timeout,
  output logic [STATE_W-1:0]        mstate,
  output logic [STEP_W-1:0]         steps
);
  localparam int AW = STATE_W + SIZE;
  localparam int RW = AW + 2;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  state_t st;
  logic [RW-1:0] rules [2**AW];
  logic [RW-1:0] entry;
  logic [STATE_W+1:0] ctl;
  logic [STEP_W-1:0] nsteps;
  assign entry = rules[{mstate, tape_read_data}];
  assign nsteps = steps + 1'b1;
  // rule table: cleared on reset, writable only while no run is in progress
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 2**AW; i++) rules[i] <= '0;
    else if (rule_wr_ena && !busy) rules[rule_addr] <= rule_data;
  // sequencer: FETCH looks up the rule for the symbol under the head, EXEC applies it
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      ctl <= '0;
      tape_head <= '0;
      tape_write_ena <= 1'b0;
      tape_write_data <= '0;
      busy <= 1'b0;
      halted <= 1'b0;
      timeout <= 1'b0;
      mstate <= '0;
      steps <= '0;
    end else begin
      case (st)
        IDLE, DONE: if (start) begin
          tape_head <= start_head;
          mstate <= '0;
          steps <= '0;
          halted <= 1'b0;
          timeout <= 1'b0;
          busy <= 1'b1;
          st <= FETCH;
        end
        FETCH: begin
          ctl <= entry[RW-1:SIZE];
          tape_write_data <= entry[SIZE-1:0];
          tape_write_ena <= 1'b1;
          st <= EXEC;
        end
        EXEC: begin
          tape_write_ena <= 1'b0;
          steps <= nsteps;
          if (ctl[STATE_W+1]) begin
            busy <= 1'b0;
            halted <= 1'b1;
            st <= DONE;
          end else begin
            tape_head <= ctl[STATE_W] ? tape_head + 3'd1 : tape_head - 3'd1;
            mstate <= ctl[STATE_W-1:0];
            if (nsteps == STEP_W'(MAX_STEPS)) begin
              timeout <= 1'b1;
              busy <= 1'b0;
              halted <= 1'b1;
              st <= DONE;
            end else st <= FETCH;
          end
        end
      endcase
    end
endmodule
